// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    // Width of the per-stage hold bus (bit 5 is reserved).
    localparam int STALL_W = 6;
    typedef logic [STALL_W-1:0] stall_bus_t;

    // Hold-bus bit index for each pipeline register.
    localparam int STG_PC   = 0;  // pc
    localparam int STG_IF   = 1;  // if/id
    localparam int STG_ID   = 2;  // id/ex
    localparam int STG_EX   = 3;  // ex/mem
    localparam int STG_WB   = 4;  // mem/wb
    localparam int STG_RSVD = 5;  // reserved, never driven high

    // Default exception handler entry point.
    localparam logic [31:0] EXCEP_ENTRY_DEF = 32'hBFC0_0380;

    // Redirect sequencer states.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_REDIRECT = 2'd3
    } state_t;

    // eret returns to EPC; every other exception goes to the handler entry.
    function automatic logic [31:0] redirect_target(
        input logic        eret,
        input logic [31:0] epc,
        input logic [31:0] entry
    );
        return eret ? epc : entry;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_prio_enc.sv
// Combinational stall-request encoder: the deepest requesting stage wins
// and holds every register upstream of (and including) itself.
module pipe_ctrl_stall_prio_enc
    import pipe_ctrl_pkg::*;
(
    input  logic       stallreq_if,
    input  logic       stallreq_id,
    input  logic       stallreq_ex,
    input  logic       stallreq_mem,
    output stall_bus_t stall_vec,
    output logic       inst_stall
);

    genvar gi;
    generate
        for (gi = 0; gi < STG_RSVD; gi++) begin : g_bit
            // Bit gi is held if any request reaches at least that deep.
            assign stall_vec[gi] = stallreq_mem
                                 | (stallreq_ex && (gi <= STG_EX))
                                 | (stallreq_id && (gi <= STG_ID))
                                 | (stallreq_if && (gi == STG_PC));
        end
    endgenerate

    assign stall_vec[STG_RSVD] = 1'b0;

    // A fetch-only stall freezes the pc and bubbles if/id so the rest drains.
    assign inst_stall = stallreq_if & ~stallreq_id & ~stallreq_ex & ~stallreq_mem;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencer: per-stage hold vector, exception/eret
// redirect sequencing and a stall-cycle performance counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXCEP_ENTRY = EXCEP_ENTRY_DEF,
    parameter int          PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_if,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              mem_exception,
    input  logic              mem_eret,
    input  logic [31:0]       cp0_epc,
    input  logic              fetch_ack,
    output logic [5:0]        stall,
    output logic              inst_stall,
    output logic              flush,
    output logic              redirect_valid,
    output logic [31:0]       new_pc,
    output logic [PERF_W-1:0] stall_cycles
);

    state_t              state_reg, state_next;
    logic [31:0]         target_reg, target_next;
    logic [PERF_W-1:0]   count_reg;
    stall_bus_t          enc_stall;
    logic                enc_inst_stall;

    pipe_ctrl_stall_prio_enc u_enc (
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .stall_vec    (enc_stall),
        .inst_stall   (enc_inst_stall)
    );

    // State and latched redirect target; reset drops straight back to RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_RUN;
            target_reg <= '0;
        end else begin
            state_reg  <= state_next;
            target_reg <= target_next;
        end
    end

    // Next state and all control outputs; outputs are forced low in reset.
    always_comb begin
        state_next     = state_reg;
        target_next    = target_reg;
        stall          = '0;
        inst_stall     = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        new_pc         = '0;
        case (state_reg)
            ST_RUN: begin
                stall      = enc_stall;
                inst_stall = enc_inst_stall;
                if (mem_exception || mem_eret) begin
                    target_next = redirect_target(mem_eret, cp0_epc, EXCEP_ENTRY);
                    // An in-flight data access must finish before we flush it.
                    state_next  = stallreq_mem ? ST_WAIT_MEM : ST_FLUSH;
                end
            end
            ST_WAIT_MEM: begin
                stall = 6'b011111;
                if (!stallreq_mem) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Flush overrides every stall request for this one cycle.
                flush          = 1'b1;
                redirect_valid = 1'b1;
                new_pc         = target_reg;
                state_next     = fetch_ack ? ST_RUN : ST_REDIRECT;
            end
            ST_REDIRECT: begin
                // pc stays held on the redirect; downstream still obeys requests.
                redirect_valid = 1'b1;
                new_pc         = target_reg;
                stall          = {1'b0, enc_stall[STG_WB:STG_IF], 1'b1};
                if (fetch_ack) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
        if (!rst) begin
            stall          = '0;
            inst_stall     = 1'b0;
            flush          = 1'b0;
            redirect_valid = 1'b0;
            new_pc         = '0;
        end
    end

    // Count every cycle that holds at least one stage; wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (stall != '0) begin
            count_reg <= count_reg + PERF_W'(1);
        end
    end

    assign stall_cycles = count_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scenario bench for pipe_ctrl: per-row expected outputs are queued when the
// stimulus is applied and popped/compared once the DUT outputs settle.
module tb_pipe_ctrl;

    localparam int PW = 4;
    localparam logic [31:0] ENTRY = 32'hBFC0_0380;
    localparam logic [31:0] EPC   = 32'h8000_1234;

    logic          clk;
    logic          rst;
    logic          stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic          mem_exception, mem_eret;
    logic [31:0]   cp0_epc;
    logic          fetch_ack;
    logic [5:0]    stall;
    logic          inst_stall, flush, redirect_valid;
    logic [31:0]   new_pc;
    logic [PW-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [8:0]  ctl;   // {stall[5:0], inst_stall, flush, redirect_valid}
        logic [31:0] pc;
    } exp_t;
    exp_t sb[$];

    pipe_ctrl #(.EXCEP_ENTRY(ENTRY), .PERF_W(PW)) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_if    (stallreq_if),
        .stallreq_id    (stallreq_id),
        .stallreq_ex    (stallreq_ex),
        .stallreq_mem   (stallreq_mem),
        .mem_exception  (mem_exception),
        .mem_eret       (mem_eret),
        .cp0_epc        (cp0_epc),
        .fetch_ack      (fetch_ack),
        .stall          (stall),
        .inst_stall     (inst_stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .new_pc         (new_pc),
        .stall_cycles   (stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stimulus word: {mem_exception, mem_eret, fetch_ack, if, id, ex, mem}
    task automatic drive(input logic [6:0] s);
        {mem_exception, mem_eret, fetch_ack, stallreq_if, stallreq_id,
         stallreq_ex, stallreq_mem} = s;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b0;
        cp0_epc = EPC;
        drive(7'b1001001);
        for (int i = 0; i < 2; i++) begin
            sb.push_back(exp_t'{9'b0, 32'h0});
            #2;
            e = sb.pop_front();
            checks++;
            if ({stall, inst_stall, flush, redirect_valid} !== e.ctl || new_pc !== e.pc) begin
                errors++;
                $display("FAIL reset[%0d] got ctl=%b pc=%h expected ctl=%b pc=%h", i,
                         {stall, inst_stall, flush, redirect_valid}, new_pc, e.ctl, e.pc);
            end
            checks++;
            if (stall_cycles !== PW'(0)) begin
                errors++;
                $display("FAIL reset_cnt[%0d] got %0d expected 0", i, stall_cycles);
            end
            $display("txn reset[%0d] ctl=%b pc=%h cnt=%0d", i,
                     {stall, inst_stall, flush, redirect_valid}, new_pc, stall_cycles);
            @(negedge clk);
        end
        rst = 1'b1;
        drive(7'b0);
        exp_cnt = 0;
    endtask

    task automatic test_priority();
        exp_t e;
        logic [6:0] stim [6] = '{7'b0000110, 7'b0001000, 7'b0001001,
                                 7'b0001100, 7'b0000000, 7'b0000010};
        logic [8:0] ctl [6]  = '{9'b001111_000, 9'b000001_100, 9'b011111_000,
                                 9'b000111_000, 9'b000000_000, 9'b001111_000};
        for (int i = 0; i < 6; i++) begin
            drive(stim[i]);
            sb.push_back(exp_t'{ctl[i], 32'h0});
            #2;
            e = sb.pop_front();
            checks++;
            if ({stall, inst_stall, flush, redirect_valid} !== e.ctl || new_pc !== e.pc) begin
                errors++;
                $display("FAIL prio[%0d] got ctl=%b pc=%h expected ctl=%b pc=%h", i,
                         {stall, inst_stall, flush, redirect_valid}, new_pc, e.ctl, e.pc);
            end
            checks++;
            if (stall_cycles !== PW'(exp_cnt)) begin
                errors++;
                $display("FAIL prio_cnt[%0d] got %0d expected %0d", i, stall_cycles, PW'(exp_cnt));
            end
            $display("txn prio[%0d] ctl=%b pc=%h cnt=%0d", i,
                     {stall, inst_stall, flush, redirect_valid}, new_pc, stall_cycles);
            if (e.ctl[8:3] != 6'b0) exp_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_exception();
        exp_t e;
        logic [6:0]  stim [4] = '{7'b1000000, 7'b0010000, 7'b0000000, 7'b0000100};
        logic [8:0]  ctl [4]  = '{9'b000000_000, 9'b000000_011, 9'b000000_000, 9'b000111_000};
        logic [31:0] pc [4]   = '{32'h0, ENTRY, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            drive(stim[i]);
            sb.push_back(exp_t'{ctl[i], pc[i]});
            #2;
            e = sb.pop_front();
            checks++;
            if ({stall, inst_stall, flush, redirect_valid} !== e.ctl || new_pc !== e.pc) begin
                errors++;
                $display("FAIL excep[%0d] got ctl=%b pc=%h expected ctl=%b pc=%h", i,
                         {stall, inst_stall, flush, redirect_valid}, new_pc, e.ctl, e.pc);
            end
            checks++;
            if (stall_cycles !== PW'(exp_cnt)) begin
                errors++;
                $display("FAIL excep_cnt[%0d] got %0d expected %0d", i, stall_cycles, PW'(exp_cnt));
            end
            $display("txn excep[%0d] ctl=%b pc=%h cnt=%0d", i,
                     {stall, inst_stall, flush, redirect_valid}, new_pc, stall_cycles);
            if (e.ctl[8:3] != 6'b0) exp_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_deferred();
        exp_t e;
        logic [6:0]  stim [7] = '{7'b1000001, 7'b0000001, 7'b0100001, 7'b0000001,
                                  7'b0000000, 7'b0010000, 7'b0000000};
        logic [8:0]  ctl [7]  = '{9'b011111_000, 9'b011111_000, 9'b011111_000, 9'b011111_000,
                                  9'b011111_000, 9'b000000_011, 9'b000000_000};
        logic [31:0] pc [7]   = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, ENTRY, 32'h0};
        for (int i = 0; i < 7; i++) begin
            drive(stim[i]);
            sb.push_back(exp_t'{ctl[i], pc[i]});
            #2;
            e = sb.pop_front();
            checks++;
            if ({stall, inst_stall, flush, redirect_valid} !== e.ctl || new_pc !== e.pc) begin
                errors++;
                $display("FAIL defer[%0d] got ctl=%b pc=%h expected ctl=%b pc=%h", i,
                         {stall, inst_stall, flush, redirect_valid}, new_pc, e.ctl, e.pc);
            end
            checks++;
            if (stall_cycles !== PW'(exp_cnt)) begin
                errors++;
                $display("FAIL defer_cnt[%0d] got %0d expected %0d", i, stall_cycles, PW'(exp_cnt));
            end
            $display("txn defer[%0d] ctl=%b pc=%h cnt=%0d", i,
                     {stall, inst_stall, flush, redirect_valid}, new_pc, stall_cycles);
            if (e.ctl[8:3] != 6'b0) exp_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_eret();
        exp_t e;
        logic [6:0]  stim [5] = '{7'b1100000, 7'b0000000, 7'b0000100, 7'b0011000, 7'b0000000};
        logic [8:0]  ctl [5]  = '{9'b000000_000, 9'b000000_011, 9'b000111_001,
                                  9'b000001_001, 9'b000000_000};
        logic [31:0] pc [5]   = '{32'h0, EPC, EPC, EPC, 32'h0};
        for (int i = 0; i < 5; i++) begin
            drive(stim[i]);
            sb.push_back(exp_t'{ctl[i], pc[i]});
            #2;
            e = sb.pop_front();
            checks++;
            if ({stall, inst_stall, flush, redirect_valid} !== e.ctl || new_pc !== e.pc) begin
                errors++;
                $display("FAIL eret[%0d] got ctl=%b pc=%h expected ctl=%b pc=%h", i,
                         {stall, inst_stall, flush, redirect_valid}, new_pc, e.ctl, e.pc);
            end
            checks++;
            if (stall_cycles !== PW'(exp_cnt)) begin
                errors++;
                $display("FAIL eret_cnt[%0d] got %0d expected %0d", i, stall_cycles, PW'(exp_cnt));
            end
            $display("txn eret[%0d] ctl=%b pc=%h cnt=%0d", i,
                     {stall, inst_stall, flush, redirect_valid}, new_pc, stall_cycles);
            if (e.ctl[8:3] != 6'b0) exp_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [6:0]  stim [6] = '{7'b1001000, 7'b0010000, 7'b1000000,
                                  7'b0000010, 7'b0010010, 7'b0000000};
        logic [8:0]  ctl [6]  = '{9'b000001_100, 9'b000000_011, 9'b000000_000,
                                  9'b000000_011, 9'b001111_001, 9'b000000_000};
        logic [31:0] pc [6]   = '{32'h0, ENTRY, 32'h0, ENTRY, ENTRY, 32'h0};
        for (int i = 0; i < 6; i++) begin
            drive(stim[i]);
            sb.push_back(exp_t'{ctl[i], pc[i]});
            #2;
            e = sb.pop_front();
            checks++;
            if ({stall, inst_stall, flush, redirect_valid} !== e.ctl || new_pc !== e.pc) begin
                errors++;
                $display("FAIL b2b[%0d] got ctl=%b pc=%h expected ctl=%b pc=%h", i,
                         {stall, inst_stall, flush, redirect_valid}, new_pc, e.ctl, e.pc);
            end
            checks++;
            if (stall_cycles !== PW'(exp_cnt)) begin
                errors++;
                $display("FAIL b2b_cnt[%0d] got %0d expected %0d", i, stall_cycles, PW'(exp_cnt));
            end
            $display("txn b2b[%0d] ctl=%b pc=%h cnt=%0d", i,
                     {stall, inst_stall, flush, redirect_valid}, new_pc, stall_cycles);
            if (e.ctl[8:3] != 6'b0) exp_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_redirect();
        exp_t e;
        logic [6:0] stim [2] = '{7'b1000000, 7'b0000000};
        logic [8:0] ctl [2]  = '{9'b000000_000, 9'b000000_011};
        logic [31:0] pc [2]  = '{32'h0, ENTRY};
        for (int i = 0; i < 2; i++) begin
            drive(stim[i]);
            sb.push_back(exp_t'{ctl[i], pc[i]});
            #2;
            e = sb.pop_front();
            checks++;
            if ({stall, inst_stall, flush, redirect_valid} !== e.ctl || new_pc !== e.pc) begin
                errors++;
                $display("FAIL midrst_pre[%0d] got ctl=%b pc=%h expected ctl=%b pc=%h", i,
                         {stall, inst_stall, flush, redirect_valid}, new_pc, e.ctl, e.pc);
            end
            $display("txn midrst_pre[%0d] ctl=%b pc=%h cnt=%0d", i,
                     {stall, inst_stall, flush, redirect_valid}, new_pc, stall_cycles);
            @(negedge clk);
        end
        // Now in REDIRECT; assert reset between clock edges.
        drive(7'b0000001);
        sb.push_back(exp_t'{9'b0, 32'h0});
        #2 rst = 1'b0;
        #1;
        e = sb.pop_front();
        checks++;
        if ({stall, inst_stall, flush, redirect_valid} !== e.ctl || new_pc !== e.pc) begin
            errors++;
            $display("FAIL midrst_async got ctl=%b pc=%h expected ctl=%b pc=%h",
                     {stall, inst_stall, flush, redirect_valid}, new_pc, e.ctl, e.pc);
        end
        checks++;
        if (stall_cycles !== PW'(0)) begin
            errors++;
            $display("FAIL midrst_cnt got %0d expected 0", stall_cycles);
        end
        $display("txn midrst_async ctl=%b pc=%h cnt=%0d",
                 {stall, inst_stall, flush, redirect_valid}, new_pc, stall_cycles);
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b1;
        drive(7'b0);
        sb.push_back(exp_t'{9'b0, 32'h0});
        #2;
        e = sb.pop_front();
        checks++;
        if ({stall, inst_stall, flush, redirect_valid} !== e.ctl || new_pc !== e.pc
            || stall_cycles !== PW'(0)) begin
            errors++;
            $display("FAIL midrst_run got ctl=%b pc=%h cnt=%0d expected ctl=%b pc=%h cnt=0",
                     {stall, inst_stall, flush, redirect_valid}, new_pc, stall_cycles, e.ctl, e.pc);
        end
        $display("txn midrst_run ctl=%b pc=%h cnt=%0d",
                 {stall, inst_stall, flush, redirect_valid}, new_pc, stall_cycles);
        @(negedge clk);
    endtask

    task automatic test_counter();
        exp_t e;
        for (int i = 0; i < 18; i++) begin
            drive(i < 17 ? 7'b0000100 : 7'b0000000);
            sb.push_back(exp_t'{(i < 17 ? 9'b000111_000 : 9'b0), 32'h0});
            #2;
            e = sb.pop_front();
            checks++;
            if ({stall, inst_stall, flush, redirect_valid} !== e.ctl || new_pc !== e.pc) begin
                errors++;
                $display("FAIL count[%0d] got ctl=%b pc=%h expected ctl=%b pc=%h", i,
                         {stall, inst_stall, flush, redirect_valid}, new_pc, e.ctl, e.pc);
            end
            checks++;
            if (stall_cycles !== PW'(exp_cnt)) begin
                errors++;
                $display("FAIL count_cnt[%0d] got %0d expected %0d", i, stall_cycles, PW'(exp_cnt));
            end
            $display("txn count[%0d] ctl=%b cnt=%0d", i,
                     {stall, inst_stall, flush, redirect_valid}, stall_cycles);
            if (e.ctl[8:3] != 6'b0) exp_cnt++;
            @(negedge clk);
        end
        // 17 stalled cycles from zero in a 4-bit counter wrap to 1.
        checks++;
        if (stall_cycles !== 4'd1) begin
            errors++;
            $display("FAIL count_wrap got %0d expected 1", stall_cycles);
        end
        $display("txn count_wrap cnt=%0d", stall_cycles);
    endtask

    initial begin
        test_reset();
        test_priority();
        test_exception();
        test_deferred();
        test_eret();
        test_back_to_back();
        test_reset_mid_redirect();
        test_counter();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline (pc, if/id, id/ex, ex/mem, mem/wb).
- Collects stall requests from IF (inst SRAM wait), ID (load-use), EX (multi-cycle div) and MEM (data SRAM wait), and drives a per-stage hold vector.
- Sequences exception/eret redirection: defers the flush until any in-flight data access completes, pulses a global flush, then holds the redirect PC until fetch accepts it.
- Keeps a stall-cycle performance counter.

Parameters:
- EXCEP_ENTRY, 32'hBFC0_0380, exception handler entry PC.
- PERF_W, 32, stall-cycle counter width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous reset, active-low; this polarity and asynchronous assertion are fixed for this block.
- stallreq_if  in  1  inst SRAM not ready.
- stallreq_id  in  1  load-use hazard.
- stallreq_ex  in  1  divider busy.
- stallreq_mem  in  1  data SRAM access in flight.
- mem_exception  in  1  MEM stage reports exception, excluding eret.
- mem_eret  in  1  MEM stage commits eret.
- cp0_epc  in  32  EPC value for eret.
- fetch_ack  in  1  PC stage accepted redirect, i.e. inst request issued.
- stall  out  6  hold per stage; bit0=pc, 1=if/id, 2=id/ex, 3=ex/mem, 4=mem/wb, 5=reserved (always 0).
- inst_stall  out  1  insert bubble into if/id.
- flush  out  1  clear all pipeline registers (drives each register's exception input).
- redirect_valid  out  1  new_pc is to be loaded.
- new_pc  out  32  redirect target.
- stall_cycles  out  PERF_W  count of cycles with stall!=0.

Behaviour:
- Reset (rst=0, asynchronous): state=RUN. All outputs are 0, including stall_cycles and new_pc.
- Stall vector, combinational from requests, with the highest stage winning:
  - mem -> 6'b011111.
  - ex -> 6'b001111.
  - id -> 6'b000111.
  - if -> 6'b000001 plus inst_stall=1 (bubble into if/id; downstream proceeds).
  - none -> 0.
- inst_stall is asserted only when stallreq_if is the sole active request.
- FSM:
  - RUN: on mem_exception|mem_eret:
    - If stallreq_mem=1, go to WAIT_MEM and latch the target (eret ? cp0_epc : EXCEP_ENTRY).
    - Otherwise, latch the target and go to FLUSH.
    - eret takes priority when both are asserted the same cycle.
  - WAIT_MEM: stall=6'b011111. When stallreq_mem drops, go to FLUSH. New exception inputs are ignored.
  - FLUSH: exactly one cycle. flush=1, stall=0, redirect_valid=1, new_pc=latched target. If fetch_ack=1 go to RUN, else go to REDIRECT.
  - REDIRECT: redirect_valid=1, stall[0]=1, flush=0. Go to RUN on fetch_ack. Incoming requests in this state affect only stall bits 1..4.
- Latency: exception seen in RUN with no mem stall -> flush=1 in the next cycle (registered state, combinational outputs from state).
- flush overrides the stall vector: stall=0 in FLUSH.
- stall_cycles: +1 per cycle with stall!=0. Wraps at 2^PERF_W-1 to 0. Not cleared by flush.
- Reset asserted mid-sequence (any state) -> RUN immediately. The latched target is cleared to 0.
- Exception and stallreq_if in the same RUN cycle: the exception path wins. The if-stall holds only the pc bit.

Decomposition:
- Shared defines.v additions:
  - STALL_BUS (5:0).
  - Stage index constants (STG_PC..STG_WB).
  - EXCEP_ENTRY default.
  - FSM state encodings (RUN=2'd0, WAIT_MEM=2'd1, FLUSH=2'd2, REDIRECT=2'd3).
- Optional sub-module stall_prio_enc: purely combinational request-to-vector encoder. The FSM and counter stay in pipe_ctrl.

Test Plan:
- Reset: rst=0 mid-REDIRECT -> stall=0, flush=0, redirect_valid=0, stall_cycles=0 asynchronously, before the next clk edge.
- Priority: stallreq_id=1, stallreq_ex=1 -> stall=6'b001111, inst_stall=0. stallreq_if=1 alone -> stall=6'b000001, inst_stall=1.
- Exception with no mem stall: mem_exception=1 at cycle N -> at N+1 flush=1, new_pc=32'hBFC00380, redirect_valid=1. With fetch_ack=1 at N+1 -> RUN at N+2.
- Deferred exception: mem_exception=1 with stallreq_mem=1 held 3 cycles -> stall=6'b011111 for those cycles, flush=0. flush=1 in the cycle after stallreq_mem falls.
- Eret redirect: mem_eret=1, cp0_epc=32'h8000_1234, fetch_ack=0 for 2 cycles -> FLUSH then 2 REDIRECT cycles with new_pc=32'h8000_1234, stall[0]=1, then RUN.
- Counter: with PERF_W=4, hold stallreq_id for 17 cycles -> stall_cycles=1 (wrap). Flush cycles do not increment.
